cpu_regfile_wb_ctrl: RTL

Write-back controller for the 2-read/1-write CPU register file. Arbitrates two write-back requesters onto the single regfile write port:
- port A: single-cycle ALU result
- port B: long-latency load/MDU result

After reset it sweeps every architectural register to zero, because the regfile array itself has no reset. Sits between the execute/memory stages and the regfile write port, and optionally forwards the pending write onto the read ports.

---
 rtl/cpu_regfile_wb_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_regfile_wb_ctrl.sv
// cpu_regfile_wb_ctrl
// Write-back controller for a 2-read/1-write CPU register file.
//  - Arbitrates port A (single-cycle ALU) and port B (long-latency load/MDU)
//    onto the single regfile write port.
//  - Port B is given forced priority after p_starve_max consecutive stalled cycles.
//  - After reset it sweeps registers 1..depth to zero, because the regfile
//    array has no reset of its own.
//  - Optional macro CPU_REGFILE_WB_BYPASS_EN forwards the pending registered
//    write onto both read ports.
//  - Without the macro, both read ports are a pure passthrough.
module cpu_regfile_wb_ctrl #(
    parameter bit          p_half_regfile   = 1'b0,
    parameter bit          p_clear_on_reset = 1'b1,
    parameter int unsigned p_starve_max     = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_busy,
    output logic        o_addr_oob,
    input  logic        i_a_valid,
    output logic        o_a_ready,
    input  logic [4:0]  i_a_addr,
    input  logic [31:0] i_a_data,
    input  logic        i_b_valid,
    output logic        o_b_ready,
    input  logic [4:0]  i_b_addr,
    input  logic [31:0] i_b_data,
    output logic        o_wr_en,
    output logic [4:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    input  logic [4:0]  i_rd1_addr,
    input  logic [31:0] i_rf_rd1_data,
    output logic [31:0] o_rd1_data,
    input  logic [4:0]  i_rd2_addr,
    input  logic [31:0] i_rf_rd2_data,
    output logic [31:0] o_rd2_data
);

    // Highest architectural register index: the sweep ends on this address.
    localparam logic [4:0] DEPTH      = p_half_regfile ? 5'd15 : 5'd31;
    localparam logic [3:0] STARVE_MAX = 4'(p_starve_max);
    localparam logic [3:0] STARVE_SAT = 4'd15;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  clr_cnt_q, clr_cnt_d;
    logic [3:0]  starve_q, starve_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        oob_q, oob_d;

    logic        force_b;
    logic        a_ready;
    logic        b_ready;
    logic        a_hs;
    logic        b_hs;
    logic        sel_b;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;
    logic        sel_oob;

    // Arbitration: B wins only when it has starved long enough; otherwise A has priority.
    // Both readies are held low in reset and while the sweep owns the write port.
    assign force_b   = (starve_q >= STARVE_MAX);
    assign a_ready   = i_rst_n && (state_q == ST_RUN) && !(force_b && i_b_valid);
    assign b_ready   = i_rst_n && (state_q == ST_RUN) && (!i_a_valid || force_b);
    assign a_hs      = i_a_valid && a_ready;
    assign b_hs      = i_b_valid && b_ready;

    // Data path of the winning requester. The readies never allow both
    // handshakes at once, so B is selected only when A did not handshake.
    assign sel_b     = b_hs && !a_hs;
    assign sel_addr  = sel_b ? i_b_addr : i_a_addr;
    assign sel_data  = sel_b ? i_b_data : i_a_data;
    assign sel_oob   = p_half_regfile && sel_addr[4];

    assign o_a_ready  = a_ready;
    assign o_b_ready  = b_ready;
    assign o_busy     = (state_q == ST_CLEAR);
    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_addr_oob = oob_q;

    // Next-state logic: the sweep sequencer, the registered write port and the starve counter.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        starve_d  = starve_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        oob_d     = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = 32'd0;
                if (clr_cnt_q == DEPTH) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + 5'd1;
                end
            end
            ST_RUN: begin
                if (a_hs || b_hs) begin
                    // Writes to r0 or beyond a half-size file are accepted
                    // but never reach the regfile.
                    wr_addr_d = sel_addr;
                    wr_data_d = sel_data;
                    wr_en_d   = (sel_addr != 5'd0) && !sel_oob;
                    oob_d     = sel_oob;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Count consecutive cycles in which B is waiting; any other cycle restarts the count.
        if (i_b_valid && !b_ready) begin
            starve_d = (starve_q == STARVE_SAT) ? STARVE_SAT : starve_q + 4'd1;
        end else begin
            starve_d = 4'd0;
        end
    end

    // State register with synchronous active-low reset; reset restarts the sweep and drops any pending write.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= p_clear_on_reset ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= 5'd1;
            starve_q  <= 4'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
            oob_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            oob_q     <= oob_d;
        end
    end

    // Read ports gathered into arrays so both are built by the same generate loop.
    logic [4:0]  rd_addr [2];
    logic [31:0] rf_rd   [2];
    logic [31:0] rd_out  [2];

    assign rd_addr[0] = i_rd1_addr;
    assign rd_addr[1] = i_rd2_addr;
    assign rf_rd[0]   = i_rf_rd1_data;
    assign rf_rd[1]   = i_rf_rd2_data;
    assign o_rd1_data = rd_out[0];
    assign o_rd2_data = rd_out[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
`ifdef CPU_REGFILE_WB_BYPASS_EN
        // Forward the write the regfile has not committed yet; r0 is never forwarded.
        assign rd_out[gi] = (wr_en_q && (wr_addr_q == rd_addr[gi]) && (rd_addr[gi] != 5'd0))
                            ? wr_data_q : rf_rd[gi];
`else
        // Passthrough: a read of the register being written this cycle sees the old value.
        assign rd_out[gi] = rf_rd[gi];
        logic unused_rd_addr;
        assign unused_rd_addr = ^rd_addr[gi];
`endif
    end

endmodule
